// File: rtl/fp_mul_stage.sv
// fp_mul_stage: multiply stage of a floating-point multiplier.
// Takes decoded operands (sign, biased exponent, significand with hidden bit,
// class flags). Produces sign, unbiased-sum exponent, the full significand
// product and product class flags. Valid/ready handshake on both sides.
// Build option FP_MUL_PIPE2_EN: adds an operand register stage, giving
// latency 2. Without it the product is registered directly, giving latency 1.
module fp_mul_stage #(
  parameter int FW = 23,
  parameter int EW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign1,
  input  logic              sign2,
  input  logic [EW-1:0]     exponent1,
  input  logic [EW-1:0]     exponent2,
  input  logic [FW:0]       significant1,
  input  logic [FW:0]       significant2,
  input  logic              inf1,
  input  logic              inf2,
  input  logic              nan1,
  input  logic              nan2,
  input  logic              zero1,
  input  logic              zero2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              p_sign,
  output logic [EW+1:0]     p_exp,
  output logic [2*FW+1:0]   p_sig,
  output logic              p_inf,
  output logic              p_nan,
  output logic              p_zero
);

  localparam logic [EW+1:0] BIAS = (EW+2)'((1 << (EW-1)) - 1);

  typedef struct packed {
    logic          sign1, sign2;
    logic [EW-1:0] exp1, exp2;
    logic [FW:0]   sig1, sig2;
    logic          inf1, inf2, nan1, nan2, zero1, zero2;
  } op_t;

  typedef struct packed {
    logic            sign;
    logic [EW+1:0]   exp;
    logic [2*FW+1:0] sig;
    logic            inf, nan, zero;
  } prod_t;

  // Product of one operand pair. Exponent 0 encodes a subnormal, which
  // behaves like exponent 1. Special results carry zero exp/sig.
  function automatic prod_t mul_fn(input op_t o);
    prod_t         r;
    logic [EW+1:0] e1, e2;
    r    = '0;
    e1   = (o.exp1 == '0) ? (EW+2)'(1) : {2'b00, o.exp1};
    e2   = (o.exp2 == '0) ? (EW+2)'(1) : {2'b00, o.exp2};
    r.nan  = o.nan1 | o.nan2 | (o.inf1 & o.zero2) | (o.zero1 & o.inf2);
    r.inf  = (o.inf1 | o.inf2) & ~r.nan;
    r.zero = (o.zero1 | o.zero2) & ~r.nan & ~r.inf;
    r.sign = (o.sign1 ^ o.sign2) & ~r.nan;
    if (!(r.nan | r.inf | r.zero)) begin
      r.exp = e1 + e2 - BIAS;
      r.sig = {{(FW+1){1'b0}}, o.sig1} * {{(FW+1){1'b0}}, o.sig2};
    end
    return r;
  endfunction

  op_t   op_d;
  prod_t prod_q;

  assign op_d = '{sign1: sign1, sign2: sign2, exp1: exponent1, exp2: exponent2,
                  sig1: significant1, sig2: significant2,
                  inf1: inf1, inf2: inf2, nan1: nan1, nan2: nan2,
                  zero1: zero1, zero2: zero2};

`ifdef FP_MUL_PIPE2_EN
  localparam int STAGES = 2;
  logic [STAGES:1] vld_pipe;
  op_t             op_q;
  logic            ld1, ld2;

  // A stage loads when it is empty or its contents drain this cycle.
  assign ld2 = ~vld_pipe[2] | out_ready;
  assign ld1 = ~vld_pipe[1] | ld2;
  assign in_ready = ld1;

  // Stage 1 holds operands, stage 2 holds the product of stage 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      op_q     <= '0;
      prod_q   <= '0;
    end else begin
      if (ld1) begin
        vld_pipe[1] <= in_valid;
        if (in_valid) op_q <= op_d;
      end
      if (ld2) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) prod_q <= mul_fn(op_q);
      end
    end
  end
`else
  localparam int STAGES = 1;
  logic [STAGES:1] vld_pipe;
  logic            ld1;

  assign ld1 = ~vld_pipe[1] | out_ready;
  assign in_ready = ld1;

  // Single stage: product registered straight from the inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      prod_q   <= '0;
    end else if (ld1) begin
      vld_pipe[1] <= in_valid;
      if (in_valid) prod_q <= mul_fn(op_d);
    end
  end
`endif

  assign out_valid = vld_pipe[STAGES];
  assign p_sign    = prod_q.sign;
  assign p_exp     = prod_q.exp;
  assign p_sig     = prod_q.sig;
  assign p_inf     = prod_q.inf;
  assign p_nan     = prod_q.nan;
  assign p_zero    = prod_q.zero;

endmodule

// File: tb/tb_fp_mul_stage.sv
// Testbench for fp_mul_stage: directed vectors plus random traffic.
// Results are checked against a queue-based arithmetic reference model.
module tb_fp_mul_stage;
  localparam int FW = 23;
  localparam int EW = 8;
  localparam int BIAS = 127;
`ifdef FP_MUL_PIPE2_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif

  typedef struct {
    bit s1, s2; int e1, e2; longint unsigned g1, g2;
    bit i1, i2, n1, n2, z1, z2;
  } op_t;
  typedef struct {
    bit sign; int exp; longint unsigned sig; bit inf, nan, zero;
  } res_t;

  logic clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic sign1, sign2, inf1, inf2, nan1, nan2, zero1, zero2;
  logic [EW-1:0] exponent1, exponent2;
  logic [FW:0] significant1, significant2;
  logic p_sign, p_inf, p_nan, p_zero;
  logic [EW+1:0] p_exp;
  logic [2*FW+1:0] p_sig;

  fp_mul_stage #(.FW(FW), .EW(EW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sign1(sign1), .sign2(sign2), .exponent1(exponent1), .exponent2(exponent2),
    .significant1(significant1), .significant2(significant2),
    .inf1(inf1), .inf2(inf2), .nan1(nan1), .nan2(nan2), .zero1(zero1), .zero2(zero2),
    .out_valid(out_valid), .out_ready(out_ready), .p_sign(p_sign), .p_exp(p_exp),
    .p_sig(p_sig), .p_inf(p_inf), .p_nan(p_nan), .p_zero(p_zero));

  initial clk = 0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_mis = 0;
  res_t q[$];
  op_t cur;
  res_t last_obs;
  bit last_ov, last_ir, stalled_prev;
  int acc_cnt = 0, fire_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: arithmetic on plain integers, straight from the product rules.
  function automatic res_t model(input op_t o);
    res_t r;
    int ex;
    r.nan  = o.n1 | o.n2 | (o.i1 & o.z2) | (o.z1 & o.i2);
    r.inf  = (o.i1 | o.i2) & !r.nan;
    r.zero = (o.z1 | o.z2) & !r.nan & !r.inf;
    r.sign = r.nan ? 1'b0 : (o.s1 ^ o.s2);
    if (r.nan || r.inf || r.zero) begin
      r.exp = 0; r.sig = 0;
    end else begin
      ex = (o.e1 == 0 ? 1 : o.e1) + (o.e2 == 0 ? 1 : o.e2) - BIAS;
      r.exp = ex & ((1 << (EW+2)) - 1);
      r.sig = o.g1 * o.g2;
    end
    return r;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.s1 = 1'($urandom); o.s2 = 1'($urandom);
    o.e1 = ($urandom_range(0,7) == 0) ? 0 : $urandom_range(0,255);
    o.e2 = ($urandom_range(0,7) == 0) ? 0 : $urandom_range(0,255);
    o.g1 = $urandom & 32'hFFFFFF; o.g2 = $urandom & 32'hFFFFFF;
    o.i1 = ($urandom_range(0,9) == 0); o.i2 = ($urandom_range(0,9) == 0);
    o.n1 = ($urandom_range(0,15) == 0); o.n2 = ($urandom_range(0,15) == 0);
    o.z1 = ($urandom_range(0,9) == 0); o.z2 = ($urandom_range(0,9) == 0);
    return o;
  endfunction

  function automatic op_t zero_op();
    op_t o;
    o.s1 = 0; o.s2 = 0; o.e1 = 0; o.e2 = 0; o.g1 = 0; o.g2 = 0;
    o.i1 = 0; o.i2 = 0; o.n1 = 0; o.n2 = 0; o.z1 = 0; o.z2 = 0;
    return o;
  endfunction

  task automatic drive(input op_t o);
    sign1 = o.s1; sign2 = o.s2;
    exponent1 = EW'(o.e1); exponent2 = EW'(o.e2);
    significant1 = (FW+1)'(o.g1); significant2 = (FW+1)'(o.g2);
    inf1 = o.i1; inf2 = o.i2; nan1 = o.n1; nan2 = o.n2; zero1 = o.z1; zero2 = o.z2;
  endtask

  // One cycle: called just after a falling edge with inputs applied.
  task automatic step();
    res_t r;
    bit fire, acc;
    #1;
    last_ov = out_valid; last_ir = in_ready;
    if (stalled_prev) chk("hold_vld", 64'(out_valid), 64'd1);
    chk("in_ready", 64'(in_ready), 64'((q.size() < STAGES) || out_ready));
    if (out_valid) begin
      last_obs.sign = p_sign; last_obs.exp = int'(p_exp); last_obs.sig = p_sig;
      last_obs.inf = p_inf; last_obs.nan = p_nan; last_obs.zero = p_zero;
      if (q.size() == 0) chk("spurious_vld", 64'(out_valid), 64'd0);
      else begin
        r = q[0];
        chk("p_sign", 64'(p_sign), 64'(r.sign));
        chk("p_exp", 64'(p_exp), 64'(r.exp));
        chk("p_sig", 64'(p_sig), r.sig);
        chk("p_flags", 64'({p_inf, p_nan, p_zero}), 64'({r.inf, r.nan, r.zero}));
      end
    end
    fire = out_valid && out_ready;
    acc  = in_valid && in_ready;
    if (fire && q.size() > 0) begin void'(q.pop_front()); fire_cnt++; end
    if (acc) begin q.push_back(model(cur)); acc_cnt++; end
    stalled_prev = out_valid && !out_ready;
    @(negedge clk);
  endtask

  // Send one pair into an empty pipe and measure cycles to out_valid.
  task automatic send_one(input op_t o);
    int lat;
    cur = o; drive(cur); in_valid = 1; out_ready = 1;
    step();
    in_valid = 0; cur = rand_op(); drive(cur);
    lat = 0;
    do begin lat++; step(); end while (!last_ov && lat < 10);
    chk("latency", 64'(lat), 64'(STAGES));
  endtask

  task automatic run(input int n, input int pin, input int prdy);
    for (int i = 0; i < n; i++) begin
      in_valid = ($urandom_range(0,99) < pin);
      out_ready = ($urandom_range(0,99) < prdy);
      cur = rand_op(); drive(cur);
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    op_t o;
    int start;
    rst_n = 0; in_valid = 0; out_ready = 0; stalled_prev = 0;
    cur = zero_op(); drive(cur);
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_payload", 64'({p_sign, p_exp, p_inf, p_nan, p_zero}), 64'd0);
    chk("rst_sig", 64'(p_sig), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;

    // 1.5 * 2.0
    o = zero_op(); o.e1 = 127; o.g1 = 'hC00000; o.e2 = 128; o.g2 = 'h800000;
    send_one(o);
    chk("v_mul_exp", 64'(last_obs.exp), 64'd128);
    chk("v_mul_sig", last_obs.sig, 64'h600000000000);
    chk("v_mul_sign_flags", 64'({last_obs.sign, last_obs.inf, last_obs.nan, last_obs.zero}), 64'd0);

    // inf * zero -> nan with forced sign 0
    o = zero_op(); o.s1 = 1; o.i1 = 1; o.e1 = 255; o.g1 = 'h800000; o.z2 = 1;
    send_one(o);
    chk("v_nan_flag", 64'(last_obs.nan), 64'd1);
    chk("v_nan_sign", 64'(last_obs.sign), 64'd0);
    chk("v_nan_sig_exp", 64'(last_obs.sig) | 64'(last_obs.exp), 64'd0);

    // subnormal operand
    o = zero_op(); o.e1 = 0; o.g1 = 1; o.e2 = 1; o.g2 = 'h800000;
    send_one(o);
    chk("v_sub_exp", 64'(last_obs.exp), 64'h383);
    chk("v_sub_sig", last_obs.sig, 64'h800000);

    // four back-to-back with 3 stalled cycles
    start = acc_cnt; fire_cnt = 0;
    for (int c = 0; c < 40 && (acc_cnt - start < 4 || q.size() > 0); c++) begin
      in_valid = (acc_cnt - start < 4);
      out_ready = (c >= 3);
      cur = rand_op(); drive(cur);
      step();
      if (c == 2) chk("v_full_in_ready", 64'(last_ir), 64'd0);
    end
    chk("v_b2b_delivered", 64'(fire_cnt), 64'd4);

    // random traffic
    run(300, 90, 100);
    run(300, 100, 30);
    run(300, 40, 90);

    // reset with products in flight
    out_ready = 0; in_valid = 1;
    for (int i = 0; i < 2; i++) begin cur = rand_op(); drive(cur); step(); end
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_sig", 64'(p_sig), 64'd0);
    q.delete(); stalled_prev = 0;
    @(negedge clk);
    rst_n = 1; out_ready = 1;
    for (int i = 0; i < 5; i++) begin cur = rand_op(); drive(cur); step(); end
    send_one(rand_op());

    // drain
    in_valid = 0; out_ready = 1;
    for (int i = 0; i < 10; i++) step();
    chk("drained", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
